// File: rtl/conv2d_multi_kernel_with_mem.sv
// conv2d_multi_kernel_with_mem: near-memory 2-D valid convolution engine.
// Acts as a bus master on a shared memory bus. It loads a HEIGHTxWIDTH matrix
// and NUM_KERN KxK kernels, computes every output pixel for every kernel with
// the given STRIDE, and writes the results back over the same bus.
// Optional feature macro: CONV_RELU_EN (negative results are written as 0).
module conv2d_multi_kernel_with_mem #(
  parameter int unsigned MAT_WIDTH     = 8,
  parameter int unsigned K_WIDTH       = 8,
  parameter int unsigned ADDR_WIDTH    = 8,
  parameter int unsigned DATABUS_WIDTH = 32,
  parameter int unsigned ACC_WIDTH     = 32,
  parameter int unsigned HEIGHT        = 4,
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned K             = 2,
  parameter int unsigned STRIDE        = 1,
  parameter int unsigned NUM_KERN      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  input  logic [ADDR_WIDTH-1:0]         matrix_addr,
  input  logic [ADDR_WIDTH-1:0]         kernel_addr,
  input  logic [ADDR_WIDTH-1:0]         output_addr,
  output logic                          mem_w,
  output logic                          mem_sel,
  inout  wire logic [ADDR_WIDTH-1:0]    address_bus,
  inout  wire logic [DATABUS_WIDTH-1:0] data_bus
);

  localparam int unsigned OUT_H = (HEIGHT - K) / STRIDE + 1;
  localparam int unsigned OUT_W = (WIDTH - K) / STRIDE + 1;
  localparam int unsigned KK    = K * K;
  localparam int unsigned MAT_N = HEIGHT * WIDTH;
  localparam int unsigned KER_N = NUM_KERN * KK;
  localparam int unsigned NPIX  = OUT_H * OUT_W;
  localparam int unsigned MIW   = (MAT_N > 1) ? $clog2(MAT_N) : 1;
  localparam int unsigned KIW   = (KER_N > 1) ? $clog2(KER_N) : 1;
  localparam int unsigned PW    = MAT_WIDTH + K_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_MAT,
    S_LOAD_KERN,
    S_COMPUTE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [31:0]                   ld_q, ld_d;
  logic [31:0]                   ki_q, ki_d, kj_q, kj_d;
  logic [31:0]                   x_q, x_d, y_q, y_d, n_q, n_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ADDR_WIDTH-1:0]         mat_base_q, mat_base_d;
  logic [ADDR_WIDTH-1:0]         kern_base_q, kern_base_d;
  logic [ADDR_WIDTH-1:0]         out_base_q, out_base_d;

  logic signed [MAT_WIDTH-1:0]   mat_q  [MAT_N];
  logic signed [K_WIDTH-1:0]     kern_q [KER_N];

  logic [MIW-1:0]                mat_idx;
  logic [KIW-1:0]                kern_idx;
  logic signed [PW-1:0]          prod;
  logic [ADDR_WIDTH-1:0]         addr_out;
  logic [DATABUS_WIDTH-1:0]      wdata;

  // Tri-state bus drivers: address only while selected, data only on writes
  assign address_bus = mem_sel ? addr_out : 'z;
  assign data_bus    = (mem_sel && mem_w) ? wdata : 'z;

  // Window element selection and full-width signed product
  always_comb begin
    mat_idx  = MIW'((y_q * STRIDE + ki_q) * WIDTH + x_q * STRIDE + kj_q);
    kern_idx = KIW'(n_q * KK + ki_q * K + kj_q);
    prod     = PW'(mat_q[mat_idx]) * PW'(kern_q[kern_idx]);
  end

  // Next-state logic: load sequencing, window walk and pixel/kernel iteration
  always_comb begin
    state_d     = state_q;
    ld_d        = ld_q;
    ki_d        = ki_q;
    kj_d        = kj_q;
    x_d         = x_q;
    y_d         = y_q;
    n_d         = n_q;
    acc_d       = acc_q;
    mat_base_d  = mat_base_q;
    kern_base_d = kern_base_q;
    out_base_d  = out_base_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD_MAT;
          mat_base_d  = matrix_addr;
          kern_base_d = kernel_addr;
          out_base_d  = output_addr;
          ld_d        = '0;
        end
      end
      S_LOAD_MAT: begin
        ld_d = ld_q + 32'd1;
        if (ld_q == MAT_N - 1) begin
          state_d = S_LOAD_KERN;
          ld_d    = '0;
        end
      end
      S_LOAD_KERN: begin
        ld_d = ld_q + 32'd1;
        if (ld_q == KER_N - 1) begin
          state_d = S_COMPUTE;
          ld_d    = '0;
          ki_d    = '0;
          kj_d    = '0;
          x_d     = '0;
          y_d     = '0;
          n_d     = '0;
          acc_d   = '0;
        end
      end
      S_COMPUTE: begin
        acc_d = acc_q + ACC_WIDTH'(prod);
        kj_d  = kj_q + 32'd1;
        if (kj_q == K - 1) begin
          kj_d = '0;
          ki_d = ki_q + 32'd1;
          if (ki_q == K - 1) begin
            ki_d    = '0;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        acc_d   = '0;
        state_d = S_COMPUTE;
        if (x_q == OUT_W - 1) begin
          x_d = '0;
          if (y_q == OUT_H - 1) begin
            y_d = '0;
            if (n_q == NUM_KERN - 1) begin
              n_d     = '0;
              state_d = S_DONE;
            end else begin
              n_d = n_q + 32'd1;
            end
          end else begin
            y_d = y_q + 32'd1;
          end
        end else begin
          x_d = x_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and status outputs decoded from state so reset releases them at once
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    mem_sel  = 1'b0;
    mem_w    = 1'b0;
    addr_out = '0;
`ifdef CONV_RELU_EN
    wdata    = acc_q[ACC_WIDTH-1] ? '0 : DATABUS_WIDTH'(acc_q);
`else
    wdata    = DATABUS_WIDTH'(acc_q);
`endif
    unique case (state_q)
      S_LOAD_MAT: begin
        mem_sel  = 1'b1;
        addr_out = mat_base_q + ADDR_WIDTH'(ld_q);
      end
      S_LOAD_KERN: begin
        mem_sel  = 1'b1;
        addr_out = kern_base_q + ADDR_WIDTH'(ld_q);
      end
      S_WRITE: begin
        mem_sel  = 1'b1;
        mem_w    = 1'b1;
        addr_out = out_base_q + ADDR_WIDTH'(n_q * NPIX + y_q * OUT_W + x_q);
      end
      default: ;
    endcase
  end

  // State, counters, accumulator and captured base addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ld_q        <= '0;
      ki_q        <= '0;
      kj_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      n_q         <= '0;
      acc_q       <= '0;
      mat_base_q  <= '0;
      kern_base_q <= '0;
      out_base_q  <= '0;
    end else begin
      state_q     <= state_d;
      ld_q        <= ld_d;
      ki_q        <= ki_d;
      kj_q        <= kj_d;
      x_q         <= x_d;
      y_q         <= y_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      mat_base_q  <= mat_base_d;
      kern_base_q <= kern_base_d;
      out_base_q  <= out_base_d;
    end
  end

  // Local operand storage, filled from the bus during the load phases
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_MAT)
      mat_q[MIW'(ld_q)] <= data_bus[MAT_WIDTH-1:0];
    if (state_q == S_LOAD_KERN)
      kern_q[KIW'(ld_q)] <= data_bus[K_WIDTH-1:0];
  end

endmodule
